ps2_tx: RTL and testbench

- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the FPGA to the keyboard.
- Companion to ps2_rx on the same PS2_KBCLK/PS2_KBDAT pair.
- Lines are open-drain. The top level builds each tristate as: pad = oe ? 1'b0 : 1'bz.
- tx_idle drives ps2_rx.rx_en so the receiver ignores host-generated traffic.

---
 rtl/ps2_pkg.sv | 24 ++
 rtl/ps2_tx_if.sv | 13 +
 rtl/ps2_line_filter.sv | 38 +++
 rtl/ps2_tx.sv | 153 +++++++++++++++
 tb/tb_ps2_tx.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 host-side blocks (ps2_tx, ps2_rx).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_REL
    } ps2_state_t;

    localparam int INHIBIT_CYCLES_DEF = 6000;
    localparam int FILTER_LEN_DEF     = 8;
    localparam int TIMEOUT_CYCLES_DEF = 1000000;

    // PS/2 frames carry odd parity: data plus parity has an odd number of ones
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Command handshake between the host logic (master) and the PS/2 transmitter (slave).
interface ps2_tx_if;
    logic       wr_ps2;
    logic [7:0] din;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       tx_err;

    modport master (output wr_ps2, output din,
                    input  tx_idle, input tx_done_tick, input tx_err);
    modport slave  (input  wr_ps2, input din,
                    output tx_idle, output tx_done_tick, output tx_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Synchronizer plus glitch filter for a PS/2 line; emits a one-cycle pulse on a filtered fall.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic line_raw,
    output logic line_filt,
    output logic fall
);

    logic                  meta;
    logic                  line_sync;
    logic [FILTER_LEN-1:0] shreg;

    // Idle PS/2 lines are high, so reset everything to 1 to avoid a spurious fall
    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= 1'b1;
            line_sync <= 1'b1;
            shreg     <= '1;
            line_filt <= 1'b1;
            fall      <= 1'b0;
        end else begin
            meta      <= line_raw;
            line_sync <= meta;
            shreg     <= {shreg[FILTER_LEN-2:0], line_sync};
            fall      <= 1'b0;
            if (&shreg) begin
                line_filt <= 1'b1;
            end else if (~|shreg) begin
                line_filt <= 1'b0;
                fall      <= line_filt;
            end
        end
    end

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the device, ack check.
// state    | meaning
// IDLE     | lines released, waiting for wr_ps2
// RTS      | clock held low for INHIBIT_CYCLES
// START    | start bit on data, waiting for first device clock
// DATA     | shifting data bits 0..7 on device clock falls
// PARITY   | parity bit on the line
// STOP     | data released as stop bit
// ACK      | sampling device ack on next fall
// WAIT_REL | waiting for device to release clock and data
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
    parameter int FILTER_LEN     = FILTER_LEN_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    ps2_tx_if.slave   bus,
    input  logic      ps2c_in,
    input  logic      ps2d_in,
    output logic      ps2c_oe,
    output logic      ps2d_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t       state;
    logic [INH_W-1:0] inh_cnt;
    logic [WD_W-1:0]  wdog;
    logic [2:0]       bit_n;
    logic [7:0]       data_q;
    logic             par_q;
    logic             ack_err;
    logic             idle_q;
    logic             done_q;
    logic             err_q;
    logic             c_filt;
    logic             c_fall;
    logic             d_meta;
    logic             d_sync;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk       (clk),
        .reset     (reset),
        .line_raw  (ps2c_in),
        .line_filt (c_filt),
        .fall      (c_fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            d_meta <= 1'b1;
            d_sync <= 1'b1;
        end else begin
            d_meta <= ps2d_in;
            d_sync <= d_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            inh_cnt <= '0;
            wdog    <= '0;
            bit_n   <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            ack_err <= 1'b0;
            ps2c_oe <= 1'b0;
            ps2d_oe <= 1'b0;
            idle_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_ps2) begin
                        data_q  <= bus.din;
                        par_q   <= odd_parity(bus.din);
                        inh_cnt <= INH_W'(INHIBIT_CYCLES - 1);
                        ps2c_oe <= 1'b1;
                        idle_q  <= 1'b0;
                        state   <= RTS;
                    end
                end
                RTS: begin
                    if (inh_cnt == '0) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b1;
                        wdog    <= WD_W'(TIMEOUT_CYCLES - 1);
                        state   <= START;
                    end else begin
                        inh_cnt <= inh_cnt - 1'b1;
                    end
                end
                default: begin
                    // Watchdog has priority over any frame progress
                    if (wdog == '0) begin
                        ps2c_oe <= 1'b0;
                        ps2d_oe <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        idle_q  <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wdog <= wdog - 1'b1;
                        case (state)
                            START: if (c_fall) begin
                                ps2d_oe <= ~data_q[0];
                                bit_n   <= '0;
                                state   <= DATA;
                            end
                            DATA: if (c_fall) begin
                                if (bit_n == 3'd7) begin
                                    ps2d_oe <= ~par_q;
                                    state   <= PARITY;
                                end else begin
                                    ps2d_oe <= ~data_q[bit_n + 3'd1];
                                    bit_n   <= bit_n + 3'd1;
                                end
                            end
                            PARITY: if (c_fall) begin
                                ps2d_oe <= 1'b0;
                                state   <= STOP;
                            end
                            STOP: if (c_fall) state <= ACK;
                            ACK: if (c_fall) begin
                                ack_err <= d_sync;
                                state   <= WAIT_REL;
                            end
                            WAIT_REL: if (c_filt && d_sync) begin
                                done_q <= 1'b1;
                                err_q  <= ack_err;
                                idle_q <= 1'b1;
                                state  <= IDLE;
                            end
                            default: state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.tx_idle      = idle_q;
    assign bus.tx_done_tick = done_q;
    assign bus.tx_err       = err_q;

endmodule

// File: tb/tb_ps2_tx.sv
// Scoreboard bench for ps2_tx with a behavioural PS/2 device on the open-drain lines.
module tb_ps2_tx;

    localparam int H = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ps2c_in, ps2d_in, ps2c_oe, ps2d_oe;
    logic dev_clk = 1'b1;
    logic dev_dat = 1'b1;
    logic glitch = 1'b0;

    int total = 0;
    int bad = 0;

    logic        exp_err_q[$];
    logic [10:0] exp_frame_q[$];
    logic        mon_exp;

    ps2_tx_if bus();

    assign ps2c_in = ~ps2c_oe & dev_clk & ~glitch;
    assign ps2d_in = ~ps2d_oe & dev_dat;

    ps2_tx #(.INHIBIT_CYCLES(6000), .FILTER_LEN(8), .TIMEOUT_CYCLES(20000)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ps2c_in (ps2c_in),
        .ps2d_in (ps2d_in),
        .ps2c_oe (ps2c_oe),
        .ps2d_oe (ps2d_oe)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every done tick must match the oldest expected outcome
    always @(negedge clk) begin
        if (bus.tx_done_tick === 1'b1) begin
            if (exp_err_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got tick want none (err=%0b)", bus.tx_err);
            end else begin
                mon_exp = exp_err_q.pop_front();
                check("tx_err", {31'd0, bus.tx_err}, {31'd0, mon_exp});
            end
        end
    end

    task automatic issue(input logic [7:0] d);
        bus.din    = d;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
    endtask

    task automatic measure_rts();
        int g = 0;
        int n = 0;
        while (!ps2c_oe && g < 100) begin g++; @(negedge clk); end
        while (ps2c_oe && n < 10000) begin n++; @(negedge clk); end
        check("rts_len", n, 6000);
    endtask

    task automatic transfer(input logic [7:0] d, input logic par, input logic ack,
                            input int glitch_bit, input int inject_bit);
        logic [10:0] frm;
        logic [10:0] exp_frm;
        logic        oe_before;
        int          g;
        exp_err_q.push_back(!ack);
        exp_frame_q.push_back({1'b1, par, d, 1'b0});
        issue(d);
        measure_rts();
        repeat (20) @(negedge clk);
        frm[0] = ps2d_in;
        for (int k = 0; k < 10; k++) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            frm[k+1] = ps2d_in;
            if (k == inject_bit) begin
                bus.din    = 8'h55;
                bus.wr_ps2 = 1'b1;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
                repeat (H-1) @(negedge clk);
            end else if (k == glitch_bit) begin
                repeat (10) @(negedge clk);
                oe_before = ps2d_oe;
                glitch = 1'b1;
                repeat (3) @(negedge clk);
                glitch = 1'b0;
                repeat (27) @(negedge clk);
                check("glitch_no_advance", {31'd0, ps2d_oe}, {31'd0, oe_before});
            end else begin
                repeat (H) @(negedge clk);
            end
        end
        exp_frm = exp_frame_q.pop_front();
        check("frame", {21'd0, frm}, {21'd0, exp_frm});
        dev_dat = ack ? 1'b0 : 1'b1;
        repeat (2) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        dev_dat = 1'b1;
        g = 0;
        while (!bus.tx_idle && g < 200) begin g++; @(negedge clk); end
        check("idle_after", {31'd0, bus.tx_idle}, 32'd1);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int n;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_c_oe", {31'd0, ps2c_oe}, 32'd0);
        check("rst_d_oe", {31'd0, ps2d_oe}, 32'd0);
        check("rst_idle", {31'd0, bus.tx_idle}, 32'd1);
        check("rst_done", {31'd0, bus.tx_done_tick}, 32'd0);
        check("rst_err", {31'd0, bus.tx_err}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED: bits 1,0,1,1,0,1,1,1 parity 1; ack given
        transfer(8'hED, 1'b1, 1'b1, -1, -1);
        // 0x01: parity 0; glitch after bit0 must not advance to bit1
        transfer(8'h01, 1'b0, 1'b1, 0, -1);
        // 0xFF: parity 1; device withholds ack
        transfer(8'hFF, 1'b1, 1'b0, -1, -1);
        // 0xED with wr_ps2/din=0x55 issued mid-DATA
        transfer(8'hED, 1'b1, 1'b1, -1, 3);
        bus.din = 8'h00;

        // Watchdog: device never clocks
        exp_err_q.push_back(1'b1);
        issue(8'hA5);
        measure_rts();
        n = 0;
        while (!bus.tx_done_tick && n < 30000) begin n++; @(negedge clk); end
        check("wdog_len", n, 20000);
        @(negedge clk);
        check("wdog_c_oe", {31'd0, ps2c_oe}, 32'd0);
        check("wdog_d_oe", {31'd0, ps2d_oe}, 32'd0);
        check("wdog_idle", {31'd0, bus.tx_idle}, 32'd1);
        repeat (5) @(negedge clk);

        // Reset mid-DATA: lines released, no done tick
        issue(8'hED);
        measure_rts();
        repeat (20) @(negedge clk);
        repeat (3) begin
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            repeat (H) @(negedge clk);
        end
        check("mid_data_busy", {31'd0, bus.tx_idle}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("mrst_c_oe", {31'd0, ps2c_oe}, 32'd0);
        check("mrst_d_oe", {31'd0, ps2d_oe}, 32'd0);
        check("mrst_idle", {31'd0, bus.tx_idle}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("mrst_still_idle", {31'd0, bus.tx_idle}, 32'd1);
        check("exp_queue_empty", exp_err_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
